adma_as_atx_split: RTL and testbench

Successor to the channel transaction fetch stage in the AXI DMA. It accepts one DMA transaction (source address, destination address, beat count) from the arbitrated channel and emits a sequence of AXI AR/AW burst descriptors. Each burst is capped by the CSR max-burst length, by ATX_LEN_W, and by the AXI 4KB boundary on each INCR side. It is a registered, FSM-driven splitter: CSRs are sampled at acceptance, outputs are stable under backpressure, and it reports channel tag, burst size and per-transaction done.

---
 rtl/adma_as_atx_split.sv | 184 ++++++++++++++++++
 tb/tb_adma_as_atx_split.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_as_atx_split.sv
// adma_as_atx_split: splits one DMA transaction into AXI AR/AW bursts.
// Ports: tx_* transaction in (vld/rdy); atx_* CSRs; ar*/aw* burst out (atx_vld/atx_rdy).
module adma_as_atx_split #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int DMA_CHN_NUM_W  = $clog2(DMA_CHN_NUM),
  parameter int DMA_LENGTH_W   = 16,
  parameter int SRC_ADDR_W     = 32,
  parameter int DST_ADDR_W     = 32,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int BEAT_BYTES     = 4,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DMA_CHN_NUM_W-1:0] tx_chn,
  input  logic [SRC_ADDR_W-1:0]    tx_src_addr,
  input  logic [DST_ADDR_W-1:0]    tx_dst_addr,
  input  logic [DMA_LENGTH_W-1:0]  tx_len,
  input  logic                     tx_vld,
  output logic                     tx_rdy,
  input  logic [MST_ID_W-1:0]      atx_id,
  input  logic [1:0]               atx_src_burst,
  input  logic [1:0]               atx_dst_burst,
  input  logic [DMA_LENGTH_W-1:0]  atx_wd_per_burst,
  output logic [MST_ID_W-1:0]      arid,
  output logic [MST_ID_W-1:0]      awid,
  output logic [SRC_ADDR_W-1:0]    araddr,
  output logic [DST_ADDR_W-1:0]    awaddr,
  output logic [ATX_LEN_W-1:0]     arlen,
  output logic [ATX_LEN_W-1:0]     awlen,
  output logic [2:0]               arsize,
  output logic [2:0]               awsize,
  output logic [1:0]               arburst,
  output logic [1:0]               awburst,
  output logic [DMA_CHN_NUM_W-1:0] atx_chn,
  output logic                     atx_vld,
  input  logic                     atx_rdy,
  output logic                     atx_start,
  output logic                     atx_start_last,
  output logic                     tx_done
);

  localparam int BB_W   = $clog2(BEAT_BYTES);
  localparam int OFF_W  = $clog2(BOUNDARY_BYTES);
  localparam int ROOM_W = OFF_W - BB_W + 1;
  localparam int REM_W  = DMA_LENGTH_W + 1;
  localparam int BT_W   = ATX_LEN_W + 1;
  localparam int CW     = REM_W + BT_W + ROOM_W;

  localparam logic [CW-1:0] CAP = CW'(1) << ATX_LEN_W;
  localparam logic [CW-1:0] BND = CW'(BOUNDARY_BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DMA_CHN_NUM_W-1:0] r_chn;
  logic [SRC_ADDR_W-1:0]    r_src;
  logic [DST_ADDR_W-1:0]    r_dst;
  logic [REM_W-1:0]         r_rem;
  logic [REM_W-1:0]         r_max;
  logic [MST_ID_W-1:0]      r_id;
  logic [1:0]               r_sburst;
  logic [1:0]               r_dburst;
  logic [BT_W-1:0]          r_beats;
  logic                     r_last;

  logic            w_src_incr;
  logic            w_dst_incr;
  logic [CW-1:0]   w_src_room;
  logic [CW-1:0]   w_dst_room;
  logic [CW-1:0]   w_beats;
  logic            w_accept;
  logic            w_hs;

  assign w_src_incr = (r_sburst == 2'b01);
  assign w_dst_incr = (r_dburst == 2'b01);

  // Beats left before the next boundary; addresses are beat-aligned.
  assign w_src_room = (BND - CW'(r_src[OFF_W-1:0])) >> BB_W;
  assign w_dst_room = (BND - CW'(r_dst[OFF_W-1:0])) >> BB_W;

  always_comb begin
    w_beats = CW'(r_rem);
    if (CW'(r_max) < w_beats) w_beats = CW'(r_max);
    if (CAP < w_beats) w_beats = CAP;
    if (w_src_incr && (w_src_room < w_beats)) w_beats = w_src_room;
    if (w_dst_incr && (w_dst_room < w_beats)) w_beats = w_dst_room;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    tx_rdy  = 1'b0;
    atx_vld = 1'b0;
    tx_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        tx_rdy = 1'b1;
        if (tx_vld) w_next = S_CALC;
      end
      S_CALC: begin
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        atx_vld = 1'b1;
        if (atx_rdy) begin
          if (r_last) begin
            tx_done = 1'b1;
            w_next  = S_IDLE;
          end else begin
            w_next = S_CALC;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = tx_vld & tx_rdy;
  assign w_hs     = atx_vld & atx_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chn    <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_rem    <= '0;
      r_max    <= '0;
      r_id     <= '0;
      r_sburst <= '0;
      r_dburst <= '0;
      r_beats  <= '0;
      r_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_chn    <= tx_chn;
        r_src    <= tx_src_addr;
        r_dst    <= tx_dst_addr;
        r_rem    <= REM_W'(tx_len) + REM_W'(1);
        r_max    <= REM_W'(atx_wd_per_burst) + REM_W'(1);
        r_id     <= atx_id;
        r_sburst <= atx_src_burst;
        r_dburst <= atx_dst_burst;
      end
      if (r_state == S_CALC) begin
        r_beats <= BT_W'(w_beats);
        r_last  <= (w_beats == CW'(r_rem));
      end
      if (w_hs && !r_last) begin
        r_rem <= r_rem - REM_W'(r_beats);
        if (w_src_incr)
          r_src <= r_src + (SRC_ADDR_W'(r_beats) << BB_W);
        if (w_dst_incr)
          r_dst <= r_dst + (DST_ADDR_W'(r_beats) << BB_W);
      end
    end
  end

  assign arid           = r_id;
  assign awid           = r_id;
  assign araddr         = r_src;
  assign awaddr         = r_dst;
  assign arlen          = ATX_LEN_W'(r_beats - BT_W'(1));
  assign awlen          = ATX_LEN_W'(r_beats - BT_W'(1));
  assign arsize         = 3'(BB_W);
  assign awsize         = 3'(BB_W);
  assign arburst        = r_sburst;
  assign awburst        = r_dburst;
  assign atx_chn        = r_chn;
  assign atx_start      = w_hs;
  assign atx_start_last = atx_vld & r_last;

endmodule

// File: tb/tb_adma_as_atx_split.sv
// tb_adma_as_atx_split: random + directed bench for adma_as_atx_split.
// Bursts are predicted by a loop-based split model and checked each cycle.
module tb_adma_as_atx_split;

  localparam int BB  = 4;
  localparam int BND = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  tx_chn;
  logic [31:0] tx_src_addr;
  logic [31:0] tx_dst_addr;
  logic [15:0] tx_len;
  logic        tx_vld;
  logic        tx_rdy;
  logic [4:0]  atx_id;
  logic [1:0]  atx_src_burst;
  logic [1:0]  atx_dst_burst;
  logic [15:0] atx_wd_per_burst;
  logic [4:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst;
  logic [1:0]  atx_chn;
  logic        atx_vld;
  logic        atx_rdy;
  logic        atx_start;
  logic        atx_start_last;
  logic        tx_done;

  always #5 clk = ~clk;

  adma_as_atx_split dut (
    .clk(clk), .rst_n(rst_n),
    .tx_chn(tx_chn), .tx_src_addr(tx_src_addr),
    .tx_dst_addr(tx_dst_addr), .tx_len(tx_len),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .atx_id(atx_id), .atx_src_burst(atx_src_burst),
    .atx_dst_burst(atx_dst_burst),
    .atx_wd_per_burst(atx_wd_per_burst),
    .arid(arid), .awid(awid),
    .araddr(araddr), .awaddr(awaddr),
    .arlen(arlen), .awlen(awlen),
    .arsize(arsize), .awsize(awsize),
    .arburst(arburst), .awburst(awburst),
    .atx_chn(atx_chn), .atx_vld(atx_vld),
    .atx_rdy(atx_rdy), .atx_start(atx_start),
    .atx_start_last(atx_start_last), .tx_done(tx_done)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] d;
    int          len;
    bit          last;
    logic [1:0]  chn;
    logic [4:0]  id;
    logic [1:0]  sb;
    logic [1:0]  db;
  } exp_t;

  exp_t q[$];
  exp_t m[$];
  int   errs = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   rdy_mode = 2;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference split: greedy largest legal burst, repeated.
  task automatic split(input logic [31:0] s, input logic [31:0] d,
                       input int len, input int wd,
                       input logic [1:0] sb, input logic [1:0] db,
                       input logic [1:0] chn, input logic [4:0] id);
    int   rem, b, room;
    exp_t e;
    m.delete();
    rem = len + 1;
    while (rem > 0) begin
      b = rem;
      if (wd + 1 < b) b = wd + 1;
      if (b > 256) b = 256;
      if (sb == 2'b01) begin
        room = (BND - int'(s % 32'(BND))) / BB;
        if (room < b) b = room;
      end
      if (db == 2'b01) begin
        room = (BND - int'(d % 32'(BND))) / BB;
        if (room < b) b = room;
      end
      e.s = s; e.d = d; e.len = b - 1;
      e.last = (b == rem);
      e.chn = chn; e.id = id; e.sb = sb; e.db = db;
      m.push_back(e);
      rem -= b;
      if (sb == 2'b01) s = s + 32'(b * BB);
      if (db == 2'b01) d = d + 32'(b * BB);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: atx_rdy = 1'($urandom_range(0, 1));
      1: atx_rdy = 1'b1;
      default: atx_rdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (tx_vld && tx_rdy) begin
        split(tx_src_addr, tx_dst_addr, int'(tx_len),
              int'(atx_wd_per_burst), atx_src_burst,
              atx_dst_burst, tx_chn, atx_id);
        foreach (m[i]) q.push_back(m[i]);
      end
      if (tx_done) done_cnt++;
      if (atx_vld) begin
        if (q.size() == 0) begin
          checks++; errs++;
          $display("FAIL extra_burst: got araddr %0h expected none",
                   araddr);
        end else begin
          chk("araddr", araddr, q[0].s);
          chk("awaddr", awaddr, q[0].d);
          chk("arlen", arlen, 64'(q[0].len));
          chk("awlen", awlen, 64'(q[0].len));
          chk("arid", arid, q[0].id);
          chk("awid", awid, q[0].id);
          chk("arburst", arburst, q[0].sb);
          chk("awburst", awburst, q[0].db);
          chk("atx_chn", atx_chn, q[0].chn);
          chk("arsize", arsize, 2);
          chk("awsize", awsize, 2);
          chk("start_last", atx_start_last, q[0].last);
          chk("tx_done", tx_done, atx_rdy & q[0].last);
          chk("atx_start", atx_start, atx_rdy);
          chk("tx_rdy_busy", tx_rdy, 0);
          if (atx_rdy) void'(q.pop_front());
        end
      end else begin
        chk("start_last_idle", atx_start_last, 0);
        chk("done_idle", tx_done, 0);
        chk("start_idle", atx_start, 0);
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] d,
                      input int len, input int wd,
                      input logic [1:0] sb, input logic [1:0] db,
                      input logic [1:0] chn, input logic [4:0] id);
    bit ok = 0;
    @(posedge clk); #1;
    tx_src_addr = s; tx_dst_addr = d; tx_len = 16'(len);
    atx_wd_per_burst = 16'(wd);
    atx_src_burst = sb; atx_dst_burst = db;
    tx_chn = chn; atx_id = id; tx_vld = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL accept_timeout: got tx_rdy 0 expected 1");
    end
    @(posedge clk); #1;
    tx_vld = 1'b0;
    tx_src_addr = $urandom; tx_dst_addr = $urandom;
    tx_len = 16'($urandom); tx_chn = 2'($urandom);
    atx_wd_per_burst = 16'($urandom_range(0, 3));
    atx_id = 5'($urandom);
    atx_src_burst = 2'($urandom); atx_dst_burst = 2'($urandom);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q.size() == 0 && tx_rdy) return;
    end
    checks++; errs++;
    $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
  endtask

  task automatic wait_vld(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (atx_vld) return;
    end
    checks++; errs++;
    $display("FAIL vld_timeout: got atx_vld 0 expected 1");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] ca, cw;
    logic [7:0]  cl;
    logic        csl;
    rst_n = 1'b0; tx_vld = 1'b0; atx_rdy = 1'b0;
    tx_chn = '0; tx_src_addr = '0; tx_dst_addr = '0; tx_len = '0;
    atx_id = '0; atx_src_burst = 2'b01; atx_dst_burst = 2'b01;
    atx_wd_per_burst = '0;

    split(32'h1000, 32'h2000, 9, 3, 2'b01, 2'b01, 2'd0, 5'd0);
    chk("pin1_n", m.size(), 3);
    chk("pin1_s1", m[1].s, 32'h1010);
    chk("pin1_d2", m[2].d, 32'h2020);
    chk("pin1_l2", m[2].len, 1);
    chk("pin1_last", {m[0].last, m[1].last, m[2].last}, 3'b001);
    split(32'h0FF8, 32'h3000, 7, 15, 2'b01, 2'b01, 2'd0, 5'd0);
    chk("pin2_n", m.size(), 2);
    chk("pin2_l0", m[0].len, 1);
    chk("pin2_s1", m[1].s, 32'h1000);
    chk("pin2_d1", m[1].d, 32'h3008);
    chk("pin2_l1", m[1].len, 5);
    split(32'h4000, 32'h5000, 5, 1, 2'b00, 2'b01, 2'd0, 5'd0);
    chk("pin3_n", m.size(), 3);
    chk("pin3_s2", m[2].s, 32'h4000);
    chk("pin3_d2", m[2].d, 32'h5010);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_rdy", tx_rdy, 1);
    chk("rst_atx_vld", atx_vld, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);

    rdy_mode = 1;
    d0 = done_cnt;
    send(32'h1000, 32'h2000, 9, 3, 2'b01, 2'b01, 2'd2, 5'h13);
    drain(200);
    chk("t1_done", done_cnt - d0, 1);
    d0 = done_cnt;
    send(32'h0FF8, 32'h3000, 7, 15, 2'b01, 2'b01, 2'd1, 5'h04);
    drain(200);
    chk("t2_done", done_cnt - d0, 1);
    send(32'h4000, 32'h5000, 5, 1, 2'b00, 2'b01, 2'd3, 5'h1F);
    drain(200);

    rdy_mode = 2;
    send(32'h0100, 32'h8000, 20, 4, 2'b01, 2'b01, 2'd1, 5'h0A);
    atx_wd_per_burst = 16'h0000;
    wait_vld(10);
    ca = araddr; cw = awaddr; cl = arlen; csl = atx_start_last;
    chk("bp_len", cl, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", atx_vld, 1);
      chk("bp_araddr", araddr, ca);
      chk("bp_awaddr", awaddr, cw);
      chk("bp_arlen", arlen, cl);
      chk("bp_sl", atx_start_last, csl);
      chk("bp_tx_rdy", tx_rdy, 0);
    end
    rdy_mode = 1;
    drain(200);

    @(posedge clk); #1;
    tx_src_addr = 32'h200; tx_dst_addr = 32'h300; tx_len = 16'd0;
    atx_wd_per_burst = 16'd7; tx_vld = 1'b1;
    @(negedge clk);
    chk("lat_idle_rdy", tx_rdy, 1);
    @(posedge clk); #1 tx_vld = 1'b0;
    @(negedge clk);
    chk("lat_calc_vld", atx_vld, 0);
    @(negedge clk);
    chk("lat_issue_vld", atx_vld, 1);
    chk("lat_arlen", arlen, 0);
    chk("lat_sl", atx_start_last, 1);
    chk("lat_done", tx_done, 1);
    @(negedge clk);
    chk("lat_rdy_back", tx_rdy, 1);
    chk("lat_vld_off", atx_vld, 0);

    send(32'h0, 32'h10000, 599, 16'h01FF, 2'b01, 2'b01, 2'd0, 5'h2);
    wait_vld(10);
    chk("clamp_arlen", arlen, 255);
    drain(400);

    rdy_mode = 2;
    send(32'h600, 32'h700, 10, 3, 2'b01, 2'b01, 2'd2, 5'h3);
    wait_vld(10);
    d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    chk("rst6_vld", atx_vld, 0);
    chk("rst6_rdy", tx_rdy, 1);
    repeat (4) @(negedge clk);
    chk("rst6_vld_later", atx_vld, 0);
    chk("rst6_no_done", done_cnt - d0, 0);

    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] s, d;
      int wd;
      s = ($urandom_range(0, 1)) ?
          (32'hFFFF_F000 | (32'($urandom_range(0, 1023)) << 2)) :
          ($urandom & 32'hFFFF_FFFC);
      d = ($urandom_range(0, 1)) ?
          (32'h0000_0F00 | (32'($urandom_range(0, 63)) << 2)) :
          ($urandom & 32'hFFFF_FFFC);
      wd = ($urandom_range(0, 1)) ? $urandom_range(0, 20) :
                                    $urandom_range(0, 600);
      d0 = done_cnt;
      send(s, d, $urandom_range(0, 200), wd,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom), 5'($urandom));
      drain(3000);
      chk("rand_done", done_cnt - d0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
